// File: rtl/register_pkg.sv
// Shared constants and helpers for the register bank and its read ports.
package register_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH = 8;

    // Address bits needed to select one of 'depth' registers (depth is a power of two).
    function automatic int unsigned addr_width(input int unsigned depth);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < depth) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/register_bank_rdport.sv
// One registered read port: address decode, write forwarding, clear and
// zero-register overrides, then the output flop.
module register_bank_rdport
    import register_pkg::*;
#(
    parameter int unsigned      WIDTH       = DEFAULT_WIDTH,
    parameter int unsigned      DEPTH       = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter bit               ZERO_REG    = 1'b0,
    parameter bit               BYPASS      = 1'b1
) (
    input  logic                          Clock,
    input  logic                          nReset,
    input  logic                          Clear,
    input  logic                          WE,
    input  logic [addr_width(DEPTH)-1:0]  WAddr,
    input  logic [WIDTH-1:0]              WData,
    input  logic [addr_width(DEPTH)-1:0]  RAddr,
    input  logic [DEPTH-1:0][WIDTH-1:0]   regs,
    output logic [WIDTH-1:0]              RData
);

    logic [WIDTH-1:0] rd_next;

    // Priority, lowest to highest: stored value, forwarded write, clear, zero register.
    always_comb begin
        rd_next = regs[RAddr];
        if (BYPASS && WE && (WAddr == RAddr)) begin
            rd_next = WData;
        end
        if (Clear) begin
            rd_next = RESET_VALUE;
        end
        if (ZERO_REG && (RAddr == '0)) begin
            rd_next = '0;
        end
    end

    // Output register, one cycle read latency.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            RData <= RESET_VALUE;
        end else begin
            RData <= rd_next;
        end
    end

endmodule

// File: rtl/register_bank.sv
// Parameterised register bank: one write port, two registered read ports.
module register_bank
    import register_pkg::*;
#(
    parameter int unsigned      WIDTH       = DEFAULT_WIDTH,
    parameter int unsigned      DEPTH       = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter bit               ZERO_REG    = 1'b0,
    parameter bit               BYPASS      = 1'b1
) (
    input  logic                          Clock,
    input  logic                          nReset,
    input  logic                          Clear,
    input  logic                          WE,
    input  logic [addr_width(DEPTH)-1:0]  WAddr,
    input  logic [WIDTH-1:0]              WData,
    input  logic [addr_width(DEPTH)-1:0]  RAddrA,
    output logic [WIDTH-1:0]              RDataA,
    input  logic [addr_width(DEPTH)-1:0]  RAddrB,
    output logic [WIDTH-1:0]              RDataB
);

    logic [DEPTH-1:0][WIDTH-1:0] regs;

    // Storage: reset and clear reload every register, otherwise single write port.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= (ZERO_REG && (i == 0)) ? '0 : RESET_VALUE;
            end
        end else if (Clear) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= (ZERO_REG && (i == 0)) ? '0 : RESET_VALUE;
            end
        end else if (WE && !(ZERO_REG && (WAddr == '0))) begin
            regs[WAddr] <= WData;
        end
    end

    register_bank_rdport #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .RESET_VALUE (RESET_VALUE),
        .ZERO_REG    (ZERO_REG),
        .BYPASS      (BYPASS)
    ) u_rdport_a (
        .Clock  (Clock),
        .nReset (nReset),
        .Clear  (Clear),
        .WE     (WE),
        .WAddr  (WAddr),
        .WData  (WData),
        .RAddr  (RAddrA),
        .regs   (regs),
        .RData  (RDataA)
    );

    register_bank_rdport #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .RESET_VALUE (RESET_VALUE),
        .ZERO_REG    (ZERO_REG),
        .BYPASS      (BYPASS)
    ) u_rdport_b (
        .Clock  (Clock),
        .nReset (nReset),
        .Clear  (Clear),
        .WE     (WE),
        .WAddr  (WAddr),
        .WData  (WData),
        .RAddr  (RAddrB),
        .regs   (regs),
        .RData  (RDataB)
    );

endmodule

// File: tb/tb_register_bank.sv
// Directed and swept checks of register_bank.
// dut_a: defaults (BYPASS=1, ZERO_REG=0, RESET_VALUE=0).
// dut_b: BYPASS=0, ZERO_REG=1, RESET_VALUE=8'h5A, same stimulus as dut_a.
// g_sweep: WIDTH {1,8,32} x DEPTH {2,64} against a reference model.
module tb_register_bank;

    logic       Clock;
    logic       nReset;
    logic       Clear;
    logic       WE;
    logic [2:0] WAddr;
    logic [7:0] WData;
    logic [2:0] RAddrA;
    logic [2:0] RAddrB;
    logic [7:0] a_rda, a_rdb, b_rda, b_rdb;

    logic        sw_clear;
    logic        sw_we;
    logic [5:0]  sw_wa;
    logic [31:0] sw_wd;
    logic [5:0]  sw_ra;
    logic [5:0]  sw_rb;
    logic [31:0] sw_rda [6];
    logic [31:0] sw_rdb [6];

    int checks = 0;
    int errors = 0;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    register_bank #(
        .WIDTH (8), .DEPTH (8), .RESET_VALUE (8'h00), .ZERO_REG (1'b0), .BYPASS (1'b1)
    ) u_dut_a (
        .Clock (Clock), .nReset (nReset), .Clear (Clear), .WE (WE),
        .WAddr (WAddr), .WData (WData),
        .RAddrA (RAddrA), .RDataA (a_rda), .RAddrB (RAddrB), .RDataB (a_rdb)
    );

    register_bank #(
        .WIDTH (8), .DEPTH (8), .RESET_VALUE (8'h5A), .ZERO_REG (1'b1), .BYPASS (1'b0)
    ) u_dut_b (
        .Clock (Clock), .nReset (nReset), .Clear (Clear), .WE (WE),
        .WAddr (WAddr), .WData (WData),
        .RAddrA (RAddrA), .RDataA (b_rda), .RAddrB (RAddrB), .RDataB (b_rdb)
    );

    for (genvar g = 0; g < 6; g++) begin : g_sweep
        localparam int unsigned SW = (g / 2 == 0) ? 1 : ((g / 2 == 1) ? 8 : 32);
        localparam int unsigned SD = (g % 2 == 0) ? 2 : 64;
        localparam int unsigned SA = (SD == 2) ? 1 : 6;
        logic [SW-1:0] rda, rdb;
        register_bank #(
            .WIDTH (SW), .DEPTH (SD)
        ) u_dut (
            .Clock (Clock), .nReset (nReset), .Clear (sw_clear), .WE (sw_we),
            .WAddr (sw_wa[SA-1:0]), .WData (sw_wd[SW-1:0]),
            .RAddrA (sw_ra[SA-1:0]), .RDataA (rda),
            .RAddrB (sw_rb[SA-1:0]), .RDataB (rdb)
        );
        assign sw_rda[g] = 32'(rda);
        assign sw_rdb[g] = 32'(rdb);
    end

    typedef struct {
        logic       clear;
        logic       we;
        logic [2:0] waddr;
        logic [7:0] wdata;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [7:0] ea_a;
        logic [7:0] ea_b;
        logic [7:0] eb_a;
        logic [7:0] eb_b;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    function automatic int unsigned sw_width(input int g);
        return (g / 2 == 0) ? 1 : ((g / 2 == 1) ? 8 : 32);
    endfunction

    function automatic int unsigned sw_depth(input int g);
        return (g % 2 == 0) ? 2 : 64;
    endfunction

    // Global time limit so the run always ends.
    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] mdl [6][64];
        logic [31:0] exp_a [6];
        logic [31:0] exp_b [6];

        //           clr   we    wa    wd     ra    rb    A.a    A.b    B.a    B.b
        vecs[0] = '{1'b0, 1'b0, 3'd0, 8'h00, 3'd4, 3'd4, 8'h00, 8'h00, 8'h5A, 8'h5A};
        vecs[1] = '{1'b0, 1'b1, 3'd3, 8'hA5, 3'd3, 3'd0, 8'hA5, 8'h00, 8'h5A, 8'h00};
        vecs[2] = '{1'b0, 1'b0, 3'd0, 8'h00, 3'd3, 3'd3, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
        vecs[3] = '{1'b0, 1'b1, 3'd5, 8'h3C, 3'd5, 3'd5, 8'h3C, 8'h3C, 8'h5A, 8'h5A};
        vecs[4] = '{1'b0, 1'b0, 3'd0, 8'h00, 3'd5, 3'd3, 8'h3C, 8'hA5, 8'h3C, 8'hA5};
        vecs[5] = '{1'b0, 1'b1, 3'd0, 8'h77, 3'd0, 3'd1, 8'h77, 8'h00, 8'h00, 8'h5A};
        vecs[6] = '{1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 8'h77, 8'h77, 8'h00, 8'h00};
        vecs[7] = '{1'b0, 1'b1, 3'd7, 8'hE1, 3'd6, 3'd7, 8'h00, 8'hE1, 8'h5A, 8'h5A};
        vecs[8] = '{1'b0, 1'b0, 3'd0, 8'h00, 3'd7, 3'd6, 8'hE1, 8'h00, 8'hE1, 8'h5A};

        Clear = 1'b0; WE = 1'b0; WAddr = '0; WData = '0; RAddrA = '0; RAddrB = '0;
        sw_clear = 1'b0; sw_we = 1'b0; sw_wa = '0; sw_wd = '0; sw_ra = '0; sw_rb = '0;
        nReset = 1'b1;

        // Reset asserted with no clock edge yet; writes offered during reset must be ignored.
        #1;
        nReset = 1'b0;
        WE = 1'b1; WAddr = 3'd4; WData = 8'h99;
        #2;
        check("reset A.rda", 32'(a_rda), 32'h00);
        check("reset A.rdb", 32'(a_rdb), 32'h00);
        check("reset B.rda", 32'(b_rda), 32'h5A);
        check("reset B.rdb", 32'(b_rdb), 32'h5A);
        #19;
        WE = 1'b0;
        nReset = 1'b1;

        for (int i = 0; i < 9; i++) begin
            Clear = vecs[i].clear; WE = vecs[i].we; WAddr = vecs[i].waddr;
            WData = vecs[i].wdata; RAddrA = vecs[i].ra; RAddrB = vecs[i].rb;
            step();
            check($sformatf("vec%0d A.rda", i), 32'(a_rda), 32'(vecs[i].ea_a));
            check($sformatf("vec%0d A.rdb", i), 32'(a_rdb), 32'(vecs[i].ea_b));
            check($sformatf("vec%0d B.rda", i), 32'(b_rda), 32'(vecs[i].eb_a));
            check($sformatf("vec%0d B.rdb", i), 32'(b_rdb), 32'(vecs[i].eb_b));
        end

        // Fill, then Clear with a competing write to addr 2.
        WE = 1'b1;
        for (int i = 0; i < 8; i++) begin
            WAddr = 3'(i);
            WData = 8'h10 + 8'(i);
            step();
        end
        Clear = 1'b1; WE = 1'b1; WAddr = 3'd2; WData = 8'hFF; RAddrA = 3'd2; RAddrB = 3'd0;
        step();
        check("clear-edge A.rda", 32'(a_rda), 32'h00);
        check("clear-edge A.rdb", 32'(a_rdb), 32'h00);
        check("clear-edge B.rda", 32'(b_rda), 32'h5A);
        check("clear-edge B.rdb", 32'(b_rdb), 32'h00);
        Clear = 1'b0; WE = 1'b0;
        for (int i = 0; i < 8; i++) begin
            RAddrA = 3'(i);
            RAddrB = 3'(i);
            step();
            check($sformatf("cleared A reg%0d", i), 32'(a_rda), 32'h00);
            check($sformatf("cleared B reg%0d", i), 32'(b_rdb), (i == 0) ? 32'h00 : 32'h5A);
        end

        // Write 0x11 to addr 1, then pulse reset between edges.
        WE = 1'b1; WAddr = 3'd1; WData = 8'h11; RAddrA = 3'd1; RAddrB = 3'd1;
        step();
        check("pre-reset A.rda", 32'(a_rda), 32'h11);
        check("pre-reset B.rda", 32'(b_rda), 32'h5A);
        WE = 1'b0;
        #2;
        nReset = 1'b0;
        #1;
        check("async A.rda", 32'(a_rda), 32'h00);
        check("async A.rdb", 32'(a_rdb), 32'h00);
        check("async B.rda", 32'(b_rda), 32'h5A);
        #2;
        nReset = 1'b1;
        step();
        check("post-reset A reg1", 32'(a_rda), 32'h00);
        check("post-reset A.rdb reg1", 32'(a_rdb), 32'h00);
        check("post-reset B reg1", 32'(b_rda), 32'h5A);

        // Parameter sweep against a reference model (all registers start at 0).
        for (int g = 0; g < 6; g++) begin
            for (int a = 0; a < 64; a++) begin
                mdl[g][a] = '0;
            end
        end
        for (int k = 0; k < 80; k++) begin
            sw_we = 1'($urandom_range(0, 1));
            sw_wa = 6'($urandom_range(0, 63));
            sw_wd = $urandom;
            sw_ra = 6'($urandom_range(0, 63));
            sw_rb = 6'($urandom_range(0, 63));
            if (k % 8 == 0) begin
                sw_we = 1'b1;
                sw_wa = 6'd63;
            end
            if (k % 3 == 0) sw_ra = sw_wa;
            if (k % 4 == 1) sw_rb = 6'd63;
            for (int g = 0; g < 6; g++) begin
                int unsigned d;
                int unsigned wi, ai, bi;
                logic [31:0] m;
                d = sw_depth(g);
                m = (sw_width(g) == 32) ? 32'hFFFF_FFFF : ((32'd1 << sw_width(g)) - 32'd1);
                wi = 32'(sw_wa) % d;
                ai = 32'(sw_ra) % d;
                bi = 32'(sw_rb) % d;
                exp_a[g] = (sw_we && (wi == ai)) ? (sw_wd & m) : mdl[g][ai];
                exp_b[g] = (sw_we && (wi == bi)) ? (sw_wd & m) : mdl[g][bi];
                if (sw_we) mdl[g][wi] = sw_wd & m;
            end
            step();
            for (int g = 0; g < 6; g++) begin
                check($sformatf("sweep%0d W%0d D%0d rda", k, sw_width(g), sw_depth(g)), sw_rda[g], exp_a[g]);
                check($sformatf("sweep%0d W%0d D%0d rdb", k, sw_width(g), sw_depth(g)), sw_rdb[g], exp_b[g]);
            end
        end

        // Final read-back of the top address in each swept configuration.
        sw_we = 1'b0; sw_ra = 6'd63; sw_rb = 6'd63;
        step();
        for (int g = 0; g < 6; g++) begin
            check($sformatf("sweep last W%0d D%0d", sw_width(g), sw_depth(g)),
                  sw_rda[g], mdl[g][sw_depth(g) - 1]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data bits per register, legal range 1..32.
REQ-002 SHALL have parameter DEPTH, default 8: register count, a power of two, 2..64; ADDR_W = log2(DEPTH).
REQ-003 SHALL have parameter RESET_VALUE, default 0: WIDTH-bit value loaded into every register on reset and Clear.
REQ-004 SHALL have parameter ZERO_REG, default 0: when 1, register 0 always reads 0 and ignores writes.
REQ-005 SHALL have parameter BYPASS, default 1: when 1, a same-cycle write to the read address is forwarded to that read port.
REQ-006 SHALL have port Clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port nReset, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port Clear, input, 1 bit: synchronous clear of all registers.
REQ-009 SHALL have port WE, input, 1 bit: write enable.
REQ-010 SHALL have port WAddr, input, ADDR_W bits: write address.
REQ-011 SHALL have port WData, input, WIDTH bits: write data.
REQ-012 SHALL have port RAddrA, input, ADDR_W bits: read address for port A.
REQ-013 SHALL have port RDataA, output, WIDTH bits: registered read data for port A.
REQ-014 SHALL have port RAddrB, input, ADDR_W bits: read address for port B.
REQ-015 SHALL have port RDataB, output, WIDTH bits: registered read data for port B.

Function
REQ-016 SHALL write WData into register[WAddr] at the rising edge when WE=1 and Clear=0.
REQ-017 SHALL load RESET_VALUE into every register at the rising edge when Clear=1; Clear overrides WE.
REQ-018 SHALL capture RDataA/RDataB at each rising edge from register[RAddrA]/register[RAddrB], giving a read latency of 1 cycle.
REQ-019 SHALL, with BYPASS=1, WE=1, Clear=0 and RAddrX=WAddr, capture WData into RDataX at that edge.
REQ-020 SHALL, with BYPASS=0, capture the pre-write register contents into RDataX for a same-cycle same-address read.
REQ-021 SHALL, with Clear=1, capture RESET_VALUE into both RDataA and RDataB at that edge, regardless of BYPASS.
REQ-022 SHALL, with ZERO_REG=1, capture 0 into RDataX whenever RAddrX=0, overriding bypass, Clear and RESET_VALUE.
REQ-023 SHALL, with ZERO_REG=1, hold register 0 at 0 and ignore writes to it.
REQ-024 SHALL support both read ports addressing the same register in the same cycle, each returning identical data.
REQ-025 SHALL hold all registers and outputs unchanged on edges with WE=0 and Clear=0, except for read capture.

Reset
REQ-026 SHALL, while nReset=0, immediately set every register to RESET_VALUE (0 for register 0 when ZERO_REG=1) and set RDataA/RDataB to the same value, with no clock edge required.
REQ-027 SHALL ignore WE and Clear while nReset=0; the first write is accepted on the first rising edge after nReset deasserts.
REQ-028 SHALL, if nReset asserts mid-cycle after a write edge, discard that write and leave all state at reset values.

Structure
REQ-029 SHALL place the default WIDTH/DEPTH constants and the address-width helper function in the shared package register_pkg.
REQ-030 SHALL factor the read path as one sub-module, register_bank_rdport, instantiated twice, containing address decode, bypass mux, zero-register override and output register.
REQ-031 SHALL contain no latches; storage is edge-triggered flops only.

Verification
REQ-032 SHALL cover basic access: reset, write 0xA5 to addr 3, then read addr 3 on A -> RDataA=0xA5 one cycle after the read address is applied.
REQ-033 SHALL cover bypass: with BYPASS=1, write 0x3C to addr 5 with RAddrA=RAddrB=5 in the same cycle -> both ports read 0x3C next cycle; with BYPASS=0 -> both ports read the old value.
REQ-034 SHALL cover Clear: fill all registers, assert Clear with WE=1, WAddr=2, WData=0xFF -> every register reads RESET_VALUE, including reg 2.
REQ-035 SHALL cover the zero register: with ZERO_REG=1, write 0x77 to addr 0 -> RDataA=0x00; with ZERO_REG=0 -> RDataA=0x77.
REQ-036 SHALL cover asynchronous reset: assert nReset between edges after writing 0x11 to addr 1 -> RDataA/RDataB go to RESET_VALUE before the next edge, and addr 1 reads RESET_VALUE after release.
REQ-037 SHALL cover parameter sweep: WIDTH in {1,8,32} and DEPTH in {2,64}, with random writes and reads checked against a reference model including last-address wrap (DEPTH-1).
